// File: rtl/i2c_pkg.sv
// Shared types and protocol constants for the I2C register target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  localparam logic [3:0] I2C_BYTE_W = 4'd8;
  localparam logic       RW_READ    = 1'b1;
  localparam logic       ACK        = 1'b0;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings SCL/SDA into the clk domain and flags edges plus START/STOP conditions.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start_det,
  output logic o_stop_det,
  output logic o_sda_s
);

  logic r_scl_meta, r_scl_s, r_scl_d;
  logic r_sda_meta, r_sda_s, r_sda_d;

  // Idle bus is high, so reset to 1 to avoid phantom edges on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_meta <= 1'b1;
      r_scl_s    <= 1'b1;
      r_scl_d    <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_s    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_meta <= i_scl;
      r_scl_s    <= r_scl_meta;
      r_scl_d    <= r_scl_s;
      r_sda_meta <= i_sda;
      r_sda_s    <= r_sda_meta;
      r_sda_d    <= r_sda_s;
    end
  end

  assign o_scl_rise  = r_scl_s & ~r_scl_d;
  assign o_scl_fall  = ~r_scl_s & r_scl_d;
  assign o_start_det = r_scl_s & r_scl_d & r_sda_d & ~r_sda_s;
  assign o_stop_det  = r_scl_s & r_scl_d & ~r_sda_d & r_sda_s;
  assign o_sda_s     = r_sda_s;

endmodule

// File: rtl/i2c_reg_target.sv
// I2C target with a byte register file: pointer write, data write, auto-increment read.
module i2c_reg_target
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 16,
  parameter int PTR_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            i_own_addr,
  input  logic                  i_scl,
  input  logic                  i_sda,
  output logic                  o_sda_oe,
  output logic                  o_busy,
  output logic                  o_wr_strobe,
  output logic [PTR_W-1:0]      o_wr_addr,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  input  logic [PTR_W-1:0]      i_host_raddr,
  output logic [DATA_WIDTH-1:0] o_host_rdata
);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda;

  i2c_bus_sync u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_scl       (i_scl),
    .i_sda       (i_sda),
    .o_scl_rise  (w_scl_rise),
    .o_scl_fall  (w_scl_fall),
    .o_start_det (w_start),
    .o_stop_det  (w_stop),
    .o_sda_s     (w_sda)
  );

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [7:0]            r_shift;
  logic [PTR_W-1:0]      r_ptr;
  logic                  r_rw;
  logic                  r_ack_drv;
  logic                  r_sda_oe;
  logic                  r_busy;
  logic                  r_wr_strobe;
  logic [PTR_W-1:0]      r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic [7:0]       w_byte;
  logic [PTR_W-1:0] w_ptr_inc;
  logic             w_last_bit;

  assign w_byte     = {r_shift[6:0], w_sda};
  assign w_ptr_inc  = r_ptr + 1'b1;
  assign w_last_bit = (r_cnt == I2C_BYTE_W - 4'd1);

  // START/STOP take priority over bit activity so a cut-off byte is never committed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_rw        <= 1'b0;
      r_ack_drv   <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_stop) begin
        r_state  <= IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state   <= ADDR;
        r_cnt     <= '0;
        r_sda_oe  <= 1'b0;
        r_ack_drv <= 1'b0;
      end else begin
        case (r_state)
          ADDR, REG, WDATA: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              r_cnt   <= w_last_bit ? 4'd0 : r_cnt + 4'd1;
              if (w_last_bit) begin
                if (r_state == ADDR) begin
                  if (w_byte[7:1] == i_own_addr) begin
                    r_rw    <= w_byte[0];
                    r_busy  <= 1'b1;
                    r_state <= ADDR_ACK;
                  end else begin
                    r_state <= IGNORE;
                  end
                end else if (r_state == REG) begin
                  r_ptr   <= w_byte[PTR_W-1:0];
                  r_state <= REG_ACK;
                end else begin
                  r_regs[r_ptr] <= w_byte;
                  r_wr_strobe   <= 1'b1;
                  r_wr_addr     <= r_ptr;
                  r_wr_data     <= w_byte;
                  r_state       <= WDATA_ACK;
                end
              end
            end
          end
          // First fall after the byte pulls SDA; the following fall ends the ACK slot.
          ADDR_ACK, REG_ACK, WDATA_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_drv) begin
                r_sda_oe  <= 1'b1;
                r_ack_drv <= 1'b1;
              end else begin
                r_ack_drv <= 1'b0;
                r_sda_oe  <= 1'b0;
                r_cnt     <= '0;
                if (r_state == ADDR_ACK) begin
                  if (r_rw == RW_READ) begin
                    r_sda_oe <= ~r_regs[r_ptr][7];
                    r_shift  <= {r_regs[r_ptr][6:0], 1'b0};
                    r_state  <= RDATA;
                  end else begin
                    r_state <= REG;
                  end
                end else if (r_state == REG_ACK) begin
                  r_state <= WDATA;
                end else begin
                  r_ptr   <= w_ptr_inc;
                  r_state <= WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (w_scl_rise) begin
              r_cnt <= r_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_cnt == I2C_BYTE_W) begin
                r_sda_oe <= 1'b0;
                r_cnt    <= '0;
                r_state  <= RDATA_ACK;
              end else begin
                r_sda_oe <= ~r_shift[7];
                r_shift  <= {r_shift[6:0], 1'b0};
              end
            end
          end
          RDATA_ACK: begin
            if (w_scl_rise) begin
              if (w_sda == ACK) begin
                r_ptr   <= w_ptr_inc;
                r_shift <= r_regs[w_ptr_inc];
                r_cnt   <= '0;
                r_state <= RDATA;
              end else begin
                r_busy  <= 1'b0;
                r_state <= IGNORE;
              end
            end
          end
          IGNORE:  r_sda_oe <= 1'b0;
          IDLE:    r_sda_oe <= 1'b0;
          default: r_state  <= IDLE;
        endcase
      end
    end
  end

  assign o_sda_oe     = r_sda_oe;
  assign o_busy       = r_busy;
  assign o_wr_strobe  = r_wr_strobe;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_host_rdata = r_regs[i_host_raddr];

endmodule

// File: tb/tb_i2c_reg_target.sv
// Self-checking bench: bit-banged I2C master plus write/read scoreboards for i2c_reg_target.
module tb_i2c_reg_target;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] ownAddr = 7'h50;
  logic       mScl = 1'b1;
  logic       mSda = 1'b1;
  logic       sdaOe, busy, wrStrobe;
  logic [3:0] wrAddr;
  logic [7:0] wrData;
  logic [3:0] hostRaddr = 4'd0;
  logic [7:0] hostRdata;
  logic       sdaLine;

  assign sdaLine = mSda & ~sdaOe;

  i2c_reg_target #(.DATA_WIDTH(8), .NUM_REGS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_own_addr   (ownAddr),
    .i_scl        (mScl),
    .i_sda        (sdaLine),
    .o_sda_oe     (sdaOe),
    .o_busy       (busy),
    .o_wr_strobe  (wrStrobe),
    .o_wr_addr    (wrAddr),
    .o_wr_data    (wrData),
    .i_host_raddr (hostRaddr),
    .o_host_rdata (hostRdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wrExp_t;

  wrExp_t     wrQ[$];
  logic [7:0] rdQ[$];
  logic [7:0] modelRegs [16];
  int         errors = 0;
  int         checks = 0;
  int         strobeCnt = 0;
  logic       sawOe = 1'b0;
  logic       sawBusy = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Write scoreboard: every committed byte must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && wrStrobe) begin
      strobeCnt++;
      if (wrQ.size() == 0) begin
        checkOutput("wr_unexpected", wrQ.size(), 1);
      end else begin
        wrExp_t e;
        e = wrQ.pop_front();
        checkOutput("wr_addr", {28'd0, wrAddr}, {28'd0, e.addr});
        checkOutput("wr_data", {24'd0, wrData}, {24'd0, e.data});
      end
    end
    if (sdaOe) sawOe = 1'b1;
    if (busy) sawBusy = 1'b1;
  end

  task automatic waitQ();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2cStart();
    mSda = 1'b1; waitQ();
    mScl = 1'b1; waitQ();
    mSda = 1'b0; waitQ();
    mScl = 1'b0; waitQ();
  endtask

  task automatic i2cStop();
    mSda = 1'b0; waitQ();
    mScl = 1'b1; waitQ();
    mSda = 1'b1; waitQ();
  endtask

  task automatic writeBit(input logic b);
    mSda = b;    waitQ();
    mScl = 1'b1; waitQ(); waitQ();
    mScl = 1'b0; waitQ();
  endtask

  task automatic readBit(output logic b);
    mSda = 1'b1; waitQ();
    mScl = 1'b1; waitQ();
    b = sdaLine; waitQ();
    mScl = 1'b0; waitQ();
  endtask

  task automatic writeByte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) writeBit(d[i]);
    readBit(ack);
  endtask

  task automatic readByte(output logic [7:0] d, input logic ackBit);
    logic b;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      readBit(b);
      d = {d[6:0], b};
    end
    writeBit(ackBit);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic expAck, input string tag);
    logic ack;
    writeByte(d, ack);
    checkOutput(tag, {31'd0, ack}, {31'd0, expAck});
  endtask

  task automatic expectWrite(input logic [3:0] a, input logic [7:0] d);
    wrExp_t e;
    e.addr = a;
    e.data = d;
    wrQ.push_back(e);
    modelRegs[a] = d;
  endtask

  task automatic hostCheck(input logic [3:0] idx, input string tag);
    hostRaddr = idx;
    @(negedge clk);
    checkOutput(tag, {24'd0, hostRdata}, {24'd0, modelRegs[idx]});
  endtask

  task automatic readCheck(input logic ackBit, input string tag);
    logic [7:0] got, exp;
    readByte(got, ackBit);
    exp = rdQ.pop_front();
    checkOutput(tag, {24'd0, got}, {24'd0, exp});
  endtask

  initial begin
    int s0;
    for (int i = 0; i < 16; i++) modelRegs[i] = 8'h00;
    repeat (5) @(negedge clk);
    checkOutput("rst_sda_oe", {31'd0, sdaOe}, 0);
    checkOutput("rst_busy", {31'd0, busy}, 0);
    checkOutput("rst_wr_strobe", {31'd0, wrStrobe}, 0);
    checkOutput("rst_wr_addr", {28'd0, wrAddr}, 0);
    checkOutput("rst_wr_data", {24'd0, wrData}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    hostCheck(4'd3, "rst_reg3");

    $display("[TB] write transaction");
    i2cStart();
    applyStimulus(8'hA0, 1'b0, "wr_addr_ack");
    checkOutput("wr_busy", {31'd0, busy}, 1);
    applyStimulus(8'h03, 1'b0, "wr_ptr_ack");
    expectWrite(4'd3, 8'h11);
    applyStimulus(8'h11, 1'b0, "wr_d0_ack");
    expectWrite(4'd4, 8'h22);
    applyStimulus(8'h22, 1'b0, "wr_d1_ack");
    i2cStop();
    repeat (5) @(negedge clk);
    checkOutput("wr_busy_stop", {31'd0, busy}, 0);
    hostCheck(4'd3, "wr_reg3");
    hostCheck(4'd4, "wr_reg4");

    $display("[TB] read via repeated start");
    i2cStart();
    applyStimulus(8'hA0, 1'b0, "rd_addrw_ack");
    applyStimulus(8'h03, 1'b0, "rd_ptr_ack");
    i2cStart();
    applyStimulus(8'hA1, 1'b0, "rd_addrr_ack");
    rdQ.push_back(modelRegs[3]);
    readCheck(1'b0, "rd_byte0");
    rdQ.push_back(modelRegs[4]);
    readCheck(1'b1, "rd_byte1");
    repeat (4) @(negedge clk);
    checkOutput("rd_oe_after_nack", {31'd0, sdaOe}, 0);
    checkOutput("rd_busy_after_nack", {31'd0, busy}, 0);
    i2cStop();
    repeat (5) @(negedge clk);

    $display("[TB] address mismatch");
    sawOe = 1'b0;
    sawBusy = 1'b0;
    s0 = strobeCnt;
    i2cStart();
    applyStimulus(8'hA2, 1'b1, "mm_addr_nack");
    applyStimulus(8'h03, 1'b1, "mm_ptr_nack");
    applyStimulus(8'hFF, 1'b1, "mm_data_nack");
    i2cStop();
    repeat (5) @(negedge clk);
    checkOutput("mm_saw_oe", {31'd0, sawOe}, 0);
    checkOutput("mm_saw_busy", {31'd0, sawBusy}, 0);
    checkOutput("mm_strobes", strobeCnt - s0, 0);

    $display("[TB] pointer wrap");
    i2cStart();
    applyStimulus(8'hA0, 1'b0, "wrap_addr_ack");
    applyStimulus(8'h1F, 1'b0, "wrap_ptr_ack");
    expectWrite(4'd15, 8'hAA);
    applyStimulus(8'hAA, 1'b0, "wrap_d0_ack");
    expectWrite(4'd0, 8'hBB);
    applyStimulus(8'hBB, 1'b0, "wrap_d1_ack");
    i2cStop();
    repeat (5) @(negedge clk);
    hostCheck(4'd15, "wrap_reg15");
    hostCheck(4'd0, "wrap_reg0");

    $display("[TB] abort mid-byte");
    s0 = strobeCnt;
    i2cStart();
    applyStimulus(8'hA0, 1'b0, "ab_addr_ack");
    applyStimulus(8'h05, 1'b0, "ab_ptr_ack");
    for (int i = 0; i < 5; i++) writeBit(1'b1);
    i2cStop();
    repeat (5) @(negedge clk);
    checkOutput("ab_strobes", strobeCnt - s0, 0);
    checkOutput("ab_oe", {31'd0, sdaOe}, 0);
    checkOutput("ab_busy", {31'd0, busy}, 0);
    hostCheck(4'd5, "ab_reg5_untouched");
    i2cStart();
    applyStimulus(8'hA0, 1'b0, "ab2_addr_ack");
    applyStimulus(8'h05, 1'b0, "ab2_ptr_ack");
    expectWrite(4'd5, 8'h5A);
    applyStimulus(8'h5A, 1'b0, "ab2_d0_ack");
    i2cStop();
    repeat (5) @(negedge clk);
    hostCheck(4'd5, "ab2_reg5");

    $display("[TB] reset mid-read");
    i2cStart();
    applyStimulus(8'hA0, 1'b0, "rr_addrw_ack");
    applyStimulus(8'h03, 1'b0, "rr_ptr_ack");
    i2cStart();
    applyStimulus(8'hA1, 1'b0, "rr_addrr_ack");
    checkOutput("rr_oe_driving", {31'd0, sdaOe}, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("rr_oe_async", {31'd0, sdaOe}, 0);
    checkOutput("rr_busy", {31'd0, busy}, 0);
    mScl = 1'b1;
    mSda = 1'b1;
    for (int i = 0; i < 16; i++) modelRegs[i] = 8'h00;
    hostCheck(4'd3, "rr_reg3");
    hostCheck(4'd4, "rr_reg4");
    hostCheck(4'd15, "rr_reg15");
    hostCheck(4'd0, "rr_reg0");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    checkOutput("wr_queue_drained", wrQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
